div14x14_seq: RTL and testbench

Sequential radix-2 restoring unsigned integer divider. It is the inverse companion of the FPU's 14x14 pipelined multiplier and is used for mantissa-slice division and reciprocal refinement in the FPU. It computes one quotient bit per enabled cycle under a load/done handshake. A clock-enable is provided so the FPU pipeline can stall it.

---
 rtl/div14x14_seq.sv | 140 ++++++++++++++
 tb/tb_div14x14_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div14x14_seq.sv
// Sequential radix-2 restoring unsigned divider: one quotient bit per enabled clock,
// load/done handshake, clock-enable stall and divide-by-zero flagging.
module div14x14_seq #(
    parameter int WID = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           ld,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    output logic [WID-1:0] q,
    output logic [WID-1:0] r,
    output logic           done,
    output logic           busy,
    output logic           dbz
);

    localparam int CW = $clog2(WID + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZCHK = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WID:0]     r_rem;
    logic [WID:0]     w_rem_next;
    logic [WID-1:0]   r_qs;
    logic [WID-1:0]   w_qs_next;
    logic [WID-1:0]   r_dv;
    logic [WID-1:0]   w_dv_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [WID-1:0]   r_q;
    logic [WID-1:0]   w_q_next;
    logic [WID-1:0]   r_r;
    logic [WID-1:0]   w_r_next;
    logic             r_done;
    logic             w_done_next;
    logic             r_dbz;
    logic             w_dbz_next;

    // Restoring step: shift the next dividend bit into the partial remainder and
    // keep the subtraction only when it does not borrow.
    logic [WID:0]     w_shift;
    logic [WID:0]     w_trial;
    logic             w_qbit;
    logic [WID:0]     w_rem_step;
    logic [WID-1:0]   w_qs_step;

    assign w_shift    = {r_rem[WID-1:0], r_qs[WID-1]};
    assign w_trial    = w_shift - {1'b0, r_dv};
    assign w_qbit     = ~w_trial[WID];
    assign w_rem_step = w_qbit ? w_trial : w_shift;
    assign w_qs_step  = {r_qs[WID-2:0], w_qbit};

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_qs_next    = r_qs;
        w_dv_next    = r_dv;
        w_cnt_next   = r_cnt;
        w_q_next     = r_q;
        w_r_next     = r_r;
        w_done_next  = r_done;
        w_dbz_next   = r_dbz;
        case (r_state)
            IDLE, DONE: begin
                if (ld) begin
                    w_qs_next    = a;
                    w_dv_next    = b;
                    w_rem_next   = '0;
                    w_cnt_next   = CW'(WID);
                    w_done_next  = 1'b0;
                    w_dbz_next   = 1'b0;
                    w_state_next = ZCHK;
                end
            end
            ZCHK: begin
                if (r_dv == '0) begin
                    // Saturated quotient; the remainder reports the untouched dividend.
                    w_q_next     = '1;
                    w_r_next     = r_qs;
                    w_dbz_next   = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_state_next = DIV;
                end
            end
            DIV: begin
                w_rem_next = w_rem_step;
                w_qs_next  = w_qs_step;
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_q_next     = w_qs_step;
                    w_r_next     = w_rem_step[WID-1:0];
                    w_done_next  = 1'b1;
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_qs    <= '0;
            r_dv    <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (ce) begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_qs    <= w_qs_next;
            r_dv    <= w_dv_next;
            r_cnt   <= w_cnt_next;
            r_q     <= w_q_next;
            r_r     <= w_r_next;
            r_done  <= w_done_next;
            r_dbz   <= w_dbz_next;
        end
    end

    assign q    = r_q;
    assign r    = r_r;
    assign done = r_done;
    assign dbz  = r_dbz;
    assign busy = (r_state == ZCHK) || (r_state == DIV);

endmodule

// File: tb/tb_div14x14_seq.sv
// Directed and random checks of div14x14_seq through an expected-result queue
// filled at load time and drained when done rises.
module tb_div14x14_seq;

    localparam int WID = 14;

    logic           clk;
    logic           rst_n;
    logic           ce;
    logic           ld;
    logic [WID-1:0] a;
    logic [WID-1:0] b;
    logic [WID-1:0] q;
    logic [WID-1:0] r;
    logic           done;
    logic           busy;
    logic           dbz;

    typedef struct {
        logic [WID-1:0] ea;
        logic [WID-1:0] eb;
        logic [WID-1:0] eq;
        logic [WID-1:0] er;
        logic           edbz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    div14x14_seq #(.WID(WID)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ce   (ce),
        .ld   (ld),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .done (done),
        .busy (busy),
        .dbz  (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive ld across one edge (the ld edge) and queue the reference result.
    task automatic start(input logic [WID-1:0] ta, input logic [WID-1:0] tb_);
        exp_t e;
        e.ea   = ta;
        e.eb   = tb_;
        e.eq   = (tb_ == 0) ? {WID{1'b1}} : ta / tb_;
        e.er   = (tb_ == 0) ? ta : ta % tb_;
        e.edbz = (tb_ == 0);
        sb.push_back(e);
        ld = 1'b1;
        a  = ta;
        b  = tb_;
        step();
        ld = 1'b0;
    endtask

    // n0 = edges already elapsed including the ld edge; exp_edges = edge count at which done is seen.
    task automatic finish_op(input string tag, input int n0, input int exp_edges);
        int   n;
        exp_t e;
        n = n0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        if (exp_edges > 0) chk({tag, "_latency"}, 64'(n), 64'(exp_edges));
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_q"}, 64'(q), 64'(e.eq));
            chk({tag, "_r"}, 64'(r), 64'(e.er));
            chk({tag, "_dbz"}, {63'd0, dbz}, {63'd0, e.edbz});
            $display("op %s: a=%0d b=%0d -> q=%0d r=%0d dbz=%0b edges=%0d",
                     tag, e.ea, e.eb, q, r, dbz, n);
        end else begin
            chk({tag, "_queue_empty"}, 64'd1, 64'(sb.size()));
        end
    endtask

    initial begin
        logic [WID-1:0] ra;
        logic [WID-1:0] rb;

        rst_n = 1'b0;
        ce    = 1'b1;
        ld    = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_flags", {61'd0, done, busy, dbz}, 64'd0);
        rst_n = 1'b1;
        step();

        // Basic divide
        start(14'd200, 14'd7);
        chk("basic_busy", {63'd0, busy}, 64'd1);
        finish_op("basic", 1, WID + 2);

        // Divide by one; the old result must survive the next load
        start(14'd16383, 14'd1);
        chk("hold_q_after_ld", 64'(q), 64'd28);
        chk("hold_done_cleared", {63'd0, done}, 64'd0);
        finish_op("div1", 1, WID + 2);
        start(14'd16383, 14'd16383);
        finish_op("divself", 1, WID + 2);

        // Dividend smaller than divisor, zero dividend
        start(14'd5, 14'd9);
        finish_op("small", 1, WID + 2);
        start(14'd0, 14'd3);
        finish_op("zero_a", 1, WID + 2);

        // Divide by zero: ZCHK only, never DIV
        start(14'd1234, 14'd0);
        chk("dbz_busy_zchk", {63'd0, busy}, 64'd1);
        finish_op("dbz", 1, 2);

        // Back-to-back load from DONE clears dbz on the ld edge
        start(14'd100, 14'd3);
        chk("dbz_cleared", {63'd0, dbz}, 64'd0);
        step();
        step();
        step();
        ld = 1'b1;
        a  = 14'd9;
        b  = 14'd2;
        step();
        ld = 1'b0;
        ce = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("stall_busy", {63'd0, busy}, 64'd1);
        chk("stall_done", {63'd0, done}, 64'd0);
        ce = 1'b1;
        finish_op("stall", 10, WID + 2 + 5);
        step();
        step();
        chk("stall_result_kept", 64'(q), 64'd33);

        // Asynchronous reset in the middle of a divide
        start(14'd1000, 14'd7);
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        #1;
        chk("arst_q", 64'(q), 64'd0);
        chk("arst_r", 64'(r), 64'd0);
        chk("arst_flags", {61'd0, done, busy, dbz}, 64'd0);
        void'(sb.pop_back());
        step();
        rst_n = 1'b1;
        step();
        chk("arst_idle_done", {63'd0, done}, 64'd0);
        start(14'd50, 14'd6);
        finish_op("after_rst", 1, WID + 2);

        // Random operands, nonzero divisor, mixed divisor magnitudes
        for (int k = 0; k < 300; k++) begin
            ra = 14'($urandom_range(16383));
            rb = (k % 2 == 0) ? 14'($urandom_range(16383, 1)) : 14'($urandom_range(63, 1));
            start(ra, rb);
            finish_op("rand", 1, WID + 2);
            chk("rand_identity", 64'(32'(q) * 32'(rb) + 32'(r)), 64'(ra));
            chk("rand_r_lt_b", {63'd0, (r < rb)}, 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
